sram_round_robin_arbiter: RTL and testbench

SRAM_ROUND_ROBIN_ARBITER -- requirements
Module: sram_round_robin_arbiter

---
 rtl/sram_round_robin_arbiter_if.sv | 66 ++++++
 rtl/sram_round_robin_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_round_robin_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_round_robin_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_round_robin_arbiter_if
//   Bundles the requester handshakes, the SRAM controller command/return
//   channel and the error flag of sram_round_robin_arbiter.
//
//   Requesters : w0/w1 (54-bit {mask,addr,data} writes),
//                r0/r1 (18-bit read addresses, 32-bit returned data)
//   SRAM side  : sram_addr_valid/sram_ready command handshake with
//                sram_addr/sram_data_in/sram_write_mask, read data returned
//                in issue order on sram_data_out/sram_data_out_valid
//   Status     : err (sticky, read data with nothing outstanding)
//
//   Modports: slave  = arbiter view
//             master = environment view (requesters + SRAM controller)
// ---------------------------------------------------------------------------
interface sram_round_robin_arbiter_if;
    logic        w0_din_valid;
    logic        w0_din_ready;
    logic [53:0] w0_din;
    logic        w1_din_valid;
    logic        w1_din_ready;
    logic [53:0] w1_din;

    logic        r0_din_valid;
    logic        r0_din_ready;
    logic [17:0] r0_din;
    logic        r0_dout_valid;
    logic [31:0] r0_dout;
    logic        r1_din_valid;
    logic        r1_din_ready;
    logic [17:0] r1_din;
    logic        r1_dout_valid;
    logic [31:0] r1_dout;

    logic        sram_addr_valid;
    logic        sram_ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;

    logic        err;

    modport slave (
        input  w0_din_valid, w0_din, w1_din_valid, w1_din,
        output w0_din_ready, w1_din_ready,
        input  r0_din_valid, r0_din, r1_din_valid, r1_din,
        output r0_din_ready, r1_din_ready,
        output r0_dout_valid, r0_dout, r1_dout_valid, r1_dout,
        output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
        input  sram_ready, sram_data_out, sram_data_out_valid,
        output err
    );

    modport master (
        output w0_din_valid, w0_din, w1_din_valid, w1_din,
        input  w0_din_ready, w1_din_ready,
        output r0_din_valid, r0_din, r1_din_valid, r1_din,
        input  r0_din_ready, r1_din_ready,
        input  r0_dout_valid, r0_dout, r1_dout_valid, r1_dout,
        input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
        output sram_ready, sram_data_out, sram_data_out_valid,
        input  err
    );
endinterface

// File: rtl/sram_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// sram_round_robin_arbiter
//   Round-robin arbiter sharing one SRAM controller between two writers
//   (w0, w1) and two readers (r0, r1). Requester index: 0=w0 1=w1 2=r0 3=r1.
//   Command fields are driven combinationally from the winner. Each issued
//   read records its reader id in a tag FIFO so in-order read data can be
//   steered back to the right reader.
//
//   Ports:
//     i_clk  - clock, rising edge
//     i_rst  - asynchronous active-high reset
//     bus    - sram_round_robin_arbiter_if.slave (requesters, SRAM, err)
//
//   Parameter:
//     TAG_DEPTH - max outstanding reads (power of 2, 2..16)
// ---------------------------------------------------------------------------
module sram_round_robin_arbiter #(
    parameter int TAG_DEPTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    sram_round_robin_arbiter_if.slave      bus
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    // ---------------- state ----------------
    logic [1:0]           r_ptr;       // round-robin start index
    logic [TAG_DEPTH-1:0] r_tag;       // reader id per outstanding read
    logic [PW-1:0]        r_wr;
    logic [PW-1:0]        r_rd;
    logic [CW-1:0]        r_cnt;
    logic                 r_err;

    // ---------------- arbitration ----------------
    logic [3:0]  w_valid;
    logic [3:0]  w_elig;
    logic        w_full;
    logic        w_empty;
    logic        w_found;
    logic [1:0]  w_win;
    logic        w_win_wr;
    logic [53:0] w_win_wdin;
    logic [17:0] w_win_raddr;
    logic        w_zero_wr;
    logic        w_cand;
    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic        w_head;
    logic [3:0]  w_rdy;

    assign w_full  = (r_cnt == CW'(TAG_DEPTH));
    assign w_empty = (r_cnt == '0);

    assign w_valid = {bus.r1_din_valid, bus.r0_din_valid,
                      bus.w1_din_valid, bus.w0_din_valid};

    // Readers need tag space as of the start of the cycle; a same-cycle
    // pop does not free a slot early.
    assign w_elig  = w_valid & {~w_full, ~w_full, 2'b11};

    // First eligible index at or after the pointer; the 2-bit add wraps mod 4.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && w_elig[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(k);
            end
        end
    end

    assign w_win_wr    = ~w_win[1];
    assign w_win_wdin  = w_win[0] ? bus.w1_din : bus.w0_din;
    assign w_win_raddr = w_win[0] ? bus.r1_din : bus.r0_din;

    // An all-zero byte mask write is a no-op: swallowed locally, never
    // reaches the SRAM and leaves the pointer alone.
    assign w_zero_wr = w_found & w_win_wr & (w_win_wdin[53:50] == 4'h0);
    assign w_cand    = w_found & ~w_zero_wr;
    assign w_issue   = w_cand & bus.sram_ready & ~i_rst;
    assign w_push    = w_issue & ~w_win_wr;

    always_comb begin
        w_rdy = 4'b0000;
        if (!i_rst && w_found)
            w_rdy[w_win] = w_zero_wr ? 1'b1 : bus.sram_ready;
    end

    assign bus.w0_din_ready = w_rdy[0];
    assign bus.w1_din_ready = w_rdy[1];
    assign bus.r0_din_ready = w_rdy[2];
    assign bus.r1_din_ready = w_rdy[3];

    // ---------------- SRAM command ----------------
    assign bus.sram_addr_valid = w_cand & ~i_rst;
    assign bus.sram_addr       = w_win_wr ? w_win_wdin[49:32] : w_win_raddr;
    assign bus.sram_data_in    = w_win_wr ? w_win_wdin[31:0]  : 32'h0;
    assign bus.sram_write_mask = w_win_wr ? w_win_wdin[53:50] : 4'h0;

    // ---------------- read return steering ----------------
    // Data arriving with nothing outstanding is dropped and flagged.
    assign w_pop  = bus.sram_data_out_valid & ~w_empty & ~i_rst;
    assign w_head = r_tag[r_rd];

    assign bus.r0_dout_valid = w_pop & ~w_head;
    assign bus.r1_dout_valid = w_pop &  w_head;
    assign bus.r0_dout       = bus.sram_data_out;
    assign bus.r1_dout       = bus.sram_data_out;
    assign bus.err           = r_err;

    // ---------------- sequential ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 2'd0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_issue)
                r_ptr <= w_win + 2'd1;
            if (w_push)
                r_wr <= r_wr + PW'(1);
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (bus.sram_data_out_valid && w_empty)
                r_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind r_cnt.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_tag[r_wr] <= w_win[0];
    end

endmodule

// File: tb/tb_sram_round_robin_arbiter.sv
module tb_sram_round_robin_arbiter;
    localparam int TD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_round_robin_arbiter_if bus();

    sram_round_robin_arbiter #(.TAG_DEPTH(TD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  rdy;
        logic        av;
        logic [17:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [1:0]  dv;
        logic        err;
        logic [31:0] dout;
    } cyc_t;

    typedef struct {
        logic [17:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } cmd_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } ret_t;

    cyc_t cyc_q[$];
    cmd_t cmd_q[$];
    ret_t ret_q[$];

    // reference model state
    int m_ptr;
    int m_tags[$];
    bit m_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [53:0] mk_w(input logic [3:0] m, input logic [17:0] a, input logic [31:0] d);
        return {m, a, d};
    endfunction

    function automatic logic [53:0] rnd_w();
        logic [3:0] m;
        m = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
        return {m, 18'($urandom), 32'($urandom)};
    endfunction

    // One cycle of stimulus; the expected response follows directly from the
    // round-robin/tag rules applied to the model state before this edge.
    task automatic drive(input logic [3:0] v, input logic [53:0] d0, input logic [53:0] d1,
                         input logic [17:0] a0, input logic [17:0] a1,
                         input logic srdy, input logic dov, input logic [31:0] dat);
        cyc_t       c;
        bit         full;
        logic [3:0] el;
        int         win;
        int         id;
        logic [53:0] wd;
        rst = 1'b0;
        bus.w0_din_valid = v[0]; bus.w0_din = d0;
        bus.w1_din_valid = v[1]; bus.w1_din = d1;
        bus.r0_din_valid = v[2]; bus.r0_din = a0;
        bus.r1_din_valid = v[3]; bus.r1_din = a1;
        bus.sram_ready = srdy;
        bus.sram_data_out_valid = dov;
        bus.sram_data_out = dat;

        c.rdy = 4'h0; c.av = 1'b0; c.addr = '0; c.data = '0; c.mask = '0;
        c.dv = 2'b00; c.err = m_err; c.dout = dat;
        full = (m_tags.size() == TD);
        el = v & {~full, ~full, 2'b11};
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && el[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        if (win >= 0) begin
            wd = (win == 1) ? d1 : d0;
            if (win < 2 && wd[53:50] == 4'h0) begin
                c.rdy[win] = 1'b1;
            end else begin
                c.av = 1'b1;
                c.rdy[win] = srdy;
                if (win < 2) begin
                    c.addr = wd[49:32]; c.data = wd[31:0]; c.mask = wd[53:50];
                end else begin
                    c.addr = (win == 2) ? a0 : a1;
                end
            end
        end
        if (dov) begin
            if (m_tags.size() > 0) begin
                id = m_tags.pop_front();
                c.dv[id] = 1'b1;
                ret_q.push_back('{id, dat});
            end else begin
                m_err = 1'b1;
            end
        end
        if (c.av && srdy) begin
            cmd_q.push_back('{c.addr, c.data, c.mask});
            m_ptr = (win + 1) % 4;
            if (win >= 2) m_tags.push_back(win - 2);
        end
        cyc_q.push_back(c);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cyc_t c;
        rst = 1'b1;
        bus.w0_din_valid = 1'($urandom); bus.w0_din = rnd_w();
        bus.w1_din_valid = 1'($urandom); bus.w1_din = rnd_w();
        bus.r0_din_valid = 1'($urandom); bus.r0_din = 18'($urandom);
        bus.r1_din_valid = 1'($urandom); bus.r1_din = 18'($urandom);
        bus.sram_ready = 1'($urandom);
        bus.sram_data_out_valid = 1'($urandom);
        bus.sram_data_out = $urandom;
        m_ptr = 0; m_tags.delete(); m_err = 1'b0;
        c.rdy = 4'h0; c.av = 1'b0; c.addr = '0; c.data = '0; c.mask = '0;
        c.dv = 2'b00; c.err = 1'b0; c.dout = bus.sram_data_out;
        cyc_q.push_back(c);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'h0, '0, '0, '0, '0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ret(input logic [31:0] d);
        drive(4'h0, '0, '0, '0, '0, 1'b0, 1'b1, d);
    endtask

    // monitor: pops one cycle record per negedge and drains the command /
    // return scoreboards whenever the DUT shows a transfer or a data pulse
    always @(negedge clk) begin
        cyc_t e;
        cmd_t ec;
        ret_t er;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("readies", {bus.r1_din_ready, bus.r0_din_ready, bus.w1_din_ready, bus.w0_din_ready}, e.rdy);
            chk("sram_addr_valid", bus.sram_addr_valid, e.av);
            if (e.av) begin
                chk("sram_addr", bus.sram_addr, e.addr);
                chk("sram_data_in", bus.sram_data_in, e.data);
                chk("sram_write_mask", bus.sram_write_mask, e.mask);
            end
            chk("dout_valid", {bus.r1_dout_valid, bus.r0_dout_valid}, e.dv);
            chk("err", bus.err, e.err);
            chk("r0_dout", bus.r0_dout, e.dout);
            chk("r1_dout", bus.r1_dout, e.dout);
            if (bus.sram_addr_valid && bus.sram_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    ec = cmd_q.pop_front();
                    chk("cmd", {bus.sram_write_mask, bus.sram_addr, bus.sram_data_in},
                        {ec.mask, ec.addr, ec.data});
                end
            end
            if (bus.r0_dout_valid || bus.r1_dout_valid) begin
                if (ret_q.size() == 0) begin
                    chk("unexpected_return", 1, 0);
                end else begin
                    er = ret_q.pop_front();
                    chk("return_id", bus.r1_dout_valid, er.id);
                    chk("return_data", bus.r0_dout, er.data);
                end
            end
        end
    end

    initial begin
        bus.w0_din_valid = 0; bus.w0_din = '0; bus.w1_din_valid = 0; bus.w1_din = '0;
        bus.r0_din_valid = 0; bus.r0_din = '0; bus.r1_din_valid = 0; bus.r1_din = '0;
        bus.sram_ready = 0; bus.sram_data_out_valid = 0; bus.sram_data_out = '0;
        m_ptr = 0; m_err = 1'b0;
        @(posedge clk); #1;
        do_reset(); do_reset();

        // all four requesters contend: w0,w1,r0,r1 rotation
        for (int i = 0; i < 8; i++)
            drive(4'hF, mk_w(4'hF, 18'(16'h100 + i), 32'(32'hA000 + i)),
                  mk_w(4'h3, 18'(16'h200 + i), 32'(32'hB000 + i)),
                  18'(16'h300 + i), 18'(16'h400 + i), 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) ret(32'(32'hC000 + i));

        // fill the tag FIFO from r0, then writes still flow while r0 is blocked
        for (int i = 0; i < TD; i++)
            drive(4'b0100, '0, '0, 18'(i), '0, 1'b1, 1'b0, 32'h0);
        drive(4'b0101, mk_w(4'h1, 18'h3FF, 32'h1234), '0, 18'h55, '0, 1'b1, 1'b0, 32'h0);
        drive(4'b0100, '0, '0, 18'h55, '0, 1'b1, 1'b1, 32'hD0);   // pop, still full
        drive(4'b0100, '0, '0, 18'h55, '0, 1'b1, 1'b0, 32'h0);    // unblocked
        for (int i = 0; i < TD; i++) ret(32'(32'hD1 + i));

        // in-order return steering
        drive(4'b0100, '0, '0, 18'h10, '0, 1'b1, 1'b0, 32'h0);
        drive(4'b1000, '0, '0, '0, 18'h20, 1'b1, 1'b0, 32'h0);
        drive(4'b0100, '0, '0, 18'h30, '0, 1'b1, 1'b0, 32'h0);
        ret(32'hA); ret(32'hB); ret(32'hC);

        // stall: w1 waits with stable fields
        for (int i = 0; i < 5; i++)
            drive(4'b0010, '0, mk_w(4'h6, 18'h2AAAA, 32'hCAFEF00D), '0, '0, 1'b0, 1'b0, 32'h0);
        drive(4'b0010, '0, mk_w(4'h6, 18'h2AAAA, 32'hCAFEF00D), '0, '0, 1'b1, 1'b0, 32'h0);

        // zero-mask write accepted while SRAM is not ready
        drive(4'b0001, mk_w(4'h0, 18'h123, 32'h9), '0, '0, '0, 1'b0, 1'b0, 32'h0);

        // stray return -> sticky err, cleared only by reset
        ret(32'hEE);
        idle(3);
        drive(4'b0001, mk_w(4'h8, 18'h7, 32'h7), '0, '0, '0, 1'b1, 1'b0, 32'h0);
        do_reset();
        idle(2);

        // outstanding tags discarded by reset
        drive(4'b0100, '0, '0, 18'h44, '0, 1'b1, 1'b0, 32'h0);
        do_reset();
        ret(32'h77);
        idle(1);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                drive(4'($urandom), rnd_w(), rnd_w(), 18'($urandom), 18'($urandom),
                      ($urandom_range(3) != 0), ($urandom_range(9) < 4), $urandom);
            end
        end
        idle(2);
        @(negedge clk); #1;
        chk("cyc_q_drained", cyc_q.size(), 0);
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("ret_q_drained", ret_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
